// File: rtl/pixel_packer_pkg.sv
// Shared word tags, FSM state encoding and the word builder for the pixel packer.
package pixel_packer_pkg;

   localparam int WORD_W = 16;

   localparam logic [3:0] TAG_FRAME = 4'hF;
   localparam logic [3:0] TAG_ROW   = 4'hA;
   localparam logic [3:0] TAG_PIX   = 4'h0;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ROW  = 1'b1
   } state_t;

   function automatic word_t mk_word(input logic [3:0] tag, input logic [11:0] payload);
      return {tag, payload};
   endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// Sequencer/ADC/host bundle of the pixel packer; slave is the packer side.
interface pixel_packer_if #(
   parameter int FIFO_AW = 10
);
   import pixel_packer_pkg::*;

   logic             FRAME_START;
   logic             MUX_START;
   logic [7:0]       ROWADD;
   logic             ADC_DATA_VALID;
   logic [11:0]      ADC_DATA;
   logic             RD_EN;
   logic             CLR_ERR;
   word_t            DOUT;
   logic             EMPTY;
   logic [FIFO_AW:0] WORD_COUNT;
   logic             ROW_DONE;
   logic             OVERFLOW;
   logic             ERR_STRAY;

   modport master (
      output FRAME_START, MUX_START, ROWADD, ADC_DATA_VALID, ADC_DATA, RD_EN, CLR_ERR,
      input  DOUT, EMPTY, WORD_COUNT, ROW_DONE, OVERFLOW, ERR_STRAY
   );

   modport slave (
      input  FRAME_START, MUX_START, ROWADD, ADC_DATA_VALID, ADC_DATA, RD_EN, CLR_ERR,
      output DOUT, EMPTY, WORD_COUNT, ROW_DONE, OVERFLOW, ERR_STRAY
   );

endinterface

// File: rtl/pix_fifo.sv
// Single-clock FIFO with registered read data; pushes while full are ignored.
// Push when full and pop when empty are both no-ops; occupancy is exported as count.
module pix_fifo
   import pixel_packer_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  word_t       wr_dat,
   input  logic        rd_en,
   output word_t       rd_dat,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   word_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign push  = wr_en & ~full;
   assign pop   = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rd_dat <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            rd_dat <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_packer.sv
// Packs frame/row headers and ADC pixels into a 16-bit word FIFO for host readout.
// Events are registered once before the FIFO write; full-FIFO writes are dropped and flagged.
module pixel_packer
   import pixel_packer_pkg::*;
#(
   parameter int N_COLS  = 128,
   parameter int FIFO_AW = 10
) (
   input  logic         CLK100MHz,
   input  logic         RESET_N,
   pixel_packer_if.slave bus
);

   localparam logic [8:0] LAST_COL = 9'(N_COLS);

   state_t     state, state_n;
   logic [7:0] frame_cnt, frame_cnt_n;
   logic [8:0] pix_cnt, pix_cnt_n;
   logic       mux_d;
   logic       mux_rise;
   logic       wr_vld, wr_vld_n;
   word_t      wr_dat, wr_dat_n;
   logic       done_q, done_n;
   logic       stray_n;
   logic       fifo_full;
   logic       row_done;
   logic       overflow;
   logic       err_stray;

   assign mux_rise = bus.MUX_START & ~mux_d;

   // Arbitration: frame start beats row start beats pixel; a losing pixel is a stray.
   always_comb begin
      state_n     = state;
      frame_cnt_n = frame_cnt;
      pix_cnt_n   = pix_cnt;
      wr_vld_n    = 1'b0;
      wr_dat_n    = wr_dat;
      done_n      = 1'b0;
      stray_n     = 1'b0;
      if (bus.FRAME_START) begin
         wr_vld_n    = 1'b1;
         wr_dat_n    = mk_word(TAG_FRAME, {4'h0, frame_cnt});
         frame_cnt_n = frame_cnt + 8'd1;
         state_n     = IDLE;
         stray_n     = bus.ADC_DATA_VALID;
      end else if (mux_rise) begin
         wr_vld_n  = 1'b1;
         wr_dat_n  = mk_word(TAG_ROW, {4'h0, bus.ROWADD});
         pix_cnt_n = '0;
         state_n   = ROW;
         stray_n   = bus.ADC_DATA_VALID;
      end else if (bus.ADC_DATA_VALID) begin
         if (state == ROW) begin
            wr_vld_n  = 1'b1;
            wr_dat_n  = mk_word(TAG_PIX, bus.ADC_DATA);
            pix_cnt_n = pix_cnt + 9'd1;
            if (pix_cnt + 9'd1 == LAST_COL) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end else begin
            stray_n = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK100MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         frame_cnt <= '0;
         pix_cnt   <= '0;
         mux_d     <= 1'b0;
         wr_vld    <= 1'b0;
         wr_dat    <= '0;
         done_q    <= 1'b0;
         row_done  <= 1'b0;
         overflow  <= 1'b0;
         err_stray <= 1'b0;
      end else begin
         state     <= state_n;
         frame_cnt <= frame_cnt_n;
         pix_cnt   <= pix_cnt_n;
         mux_d     <= bus.MUX_START;
         wr_vld    <= wr_vld_n;
         wr_dat    <= wr_dat_n;
         done_q    <= done_n;
         // ROW_DONE lines up with the edge that actually stores the last pixel.
         row_done  <= done_q;
         overflow  <= (overflow & ~bus.CLR_ERR) | (wr_vld & fifo_full);
         err_stray <= (err_stray & ~bus.CLR_ERR) | stray_n;
      end
   end

   pix_fifo #(
      .AW(FIFO_AW)
   ) u_fifo (
      .clk    (CLK100MHz),
      .rst_n  (RESET_N),
      .wr_en  (wr_vld),
      .wr_dat (wr_dat),
      .rd_en  (bus.RD_EN),
      .rd_dat (bus.DOUT),
      .full   (fifo_full),
      .empty  (bus.EMPTY),
      .count  (bus.WORD_COUNT)
   );

   assign bus.ROW_DONE  = row_done;
   assign bus.OVERFLOW  = overflow;
   assign bus.ERR_STRAY = err_stray;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer with N_COLS=4, FIFO_AW=3: vector table plus corner-case sequences.
module tb_pixel_packer;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   pixel_packer_if #(.FIFO_AW(3)) bus ();

   pixel_packer #(
      .N_COLS (4),
      .FIFO_AW(3)
   ) dut (
      .CLK100MHz(clk),
      .RESET_N  (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fs;
      logic        mux;
      logic [7:0]  row;
      logic        vld;
      logic [11:0] adc;
      logic        rd;
      logic        clr;
      logic [3:0]  wc;
      logic        emp;
      logic        rdone;
      logic        ov;
      logic        es;
      logic [15:0] dout;
   } vec_t;

   vec_t tbl[$];

   task automatic v(input logic fs, input logic mux, input logic [7:0] row, input logic vld,
                    input logic [11:0] adc, input logic rd, input logic clr, input logic [3:0] wc,
                    input logic emp, input logic rdone, input logic ov, input logic es,
                    input logic [15:0] dout);
      vec_t r;
      r.fs = fs; r.mux = mux; r.row = row; r.vld = vld; r.adc = adc; r.rd = rd; r.clr = clr;
      r.wc = wc; r.emp = emp; r.rdone = rdone; r.ov = ov; r.es = es; r.dout = dout;
      tbl.push_back(r);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.FRAME_START    = 1'b0;
      bus.MUX_START      = 1'b0;
      bus.ROWADD         = 8'h00;
      bus.ADC_DATA_VALID = 1'b0;
      bus.ADC_DATA       = 12'h000;
      bus.RD_EN          = 1'b0;
      bus.CLR_ERR        = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Snapshot layout: {wc[3:0], empty, row_done, overflow, err_stray, dout[15:0]}
   function automatic logic [31:0] snap();
      return {8'h00, bus.WORD_COUNT, bus.EMPTY, bus.ROW_DONE, bus.OVERFLOW, bus.ERR_STRAY, bus.DOUT};
   endfunction

   task automatic pop_check(input string name, input logic [15:0] exp);
      bus.RD_EN = 1'b1;
      step();
      bus.RD_EN = 1'b0;
      check(name, {16'h0, bus.DOUT}, {16'h0, exp});
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("reset_state", snap(), {8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      step();
      step();
      rst_n = 1'b1;
      step();

      //  fs mux row   vld adc     rd clr  wc emp rd ov es dout
      v(1, 0, 8'd0, 0, 12'h000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);
      v(0, 1, 8'd5, 0, 12'h000, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
      v(0, 1, 8'd5, 1, 12'h001, 0, 0, 2, 0, 0, 0, 0, 16'h0000);
      v(0, 1, 8'd5, 1, 12'h002, 0, 0, 3, 0, 0, 0, 0, 16'h0000);
      v(0, 1, 8'd5, 1, 12'h003, 0, 0, 4, 0, 0, 0, 0, 16'h0000);
      v(0, 1, 8'd5, 1, 12'h004, 0, 0, 5, 0, 0, 0, 0, 16'h0000);
      v(0, 0, 8'd0, 0, 12'h000, 0, 0, 6, 0, 1, 0, 0, 16'h0000);
      v(0, 0, 8'd0, 0, 12'h000, 0, 0, 6, 0, 0, 0, 0, 16'h0000);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 5, 0, 0, 0, 0, 16'hF000);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 4, 0, 0, 0, 0, 16'hA005);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 3, 0, 0, 0, 0, 16'h0001);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 2, 0, 0, 0, 0, 16'h0002);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 1, 0, 0, 0, 0, 16'h0003);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 0, 1, 0, 0, 0, 16'h0004);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 0, 1, 0, 0, 0, 16'h0004);
      // stray strobe with no row open, then clear (with a same-cycle new error case)
      v(0, 0, 8'd0, 1, 12'h007, 0, 0, 0, 1, 0, 0, 1, 16'h0004);
      v(0, 0, 8'd0, 0, 12'h000, 0, 0, 0, 1, 0, 0, 1, 16'h0004);
      v(0, 0, 8'd0, 0, 12'h000, 0, 1, 0, 1, 0, 0, 0, 16'h0004);
      v(0, 0, 8'd0, 1, 12'h008, 0, 1, 0, 1, 0, 0, 1, 16'h0004);
      v(0, 0, 8'd0, 0, 12'h000, 0, 1, 0, 1, 0, 0, 0, 16'h0004);
      // frame start collides with a strobe two pixels into a row; read+write in one cycle
      v(1, 0, 8'd0, 0, 12'h000, 0, 0, 0, 1, 0, 0, 0, 16'h0004);
      v(0, 1, 8'd3, 0, 12'h000, 0, 0, 1, 0, 0, 0, 0, 16'h0004);
      v(0, 1, 8'd3, 1, 12'h0AB, 1, 0, 1, 0, 0, 0, 0, 16'hF001);
      v(0, 1, 8'd3, 1, 12'h0CD, 0, 0, 2, 0, 0, 0, 0, 16'hF001);
      v(1, 1, 8'd3, 1, 12'hEEE, 0, 0, 3, 0, 0, 0, 1, 16'hF001);
      v(0, 0, 8'd0, 0, 12'h000, 0, 0, 4, 0, 0, 0, 1, 16'hF001);
      v(0, 0, 8'd0, 0, 12'h000, 0, 1, 4, 0, 0, 0, 0, 16'hF001);
      v(0, 0, 8'd0, 1, 12'h111, 0, 0, 4, 0, 0, 0, 1, 16'hF001);
      v(0, 0, 8'd0, 0, 12'h000, 0, 0, 4, 0, 0, 0, 1, 16'hF001);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 3, 0, 0, 0, 1, 16'hA003);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 2, 0, 0, 0, 1, 16'h00AB);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 1, 0, 0, 0, 1, 16'h00CD);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 0, 1, 0, 0, 1, 16'hF002);
      v(0, 0, 8'd0, 0, 12'h000, 0, 1, 0, 1, 0, 0, 0, 16'hF002);
      // row restarted by a second MUX_START rise: pixel count starts over
      v(0, 1, 8'd7, 0, 12'h000, 0, 0, 0, 1, 0, 0, 0, 16'hF002);
      v(0, 1, 8'd7, 1, 12'h005, 0, 0, 1, 0, 0, 0, 0, 16'hF002);
      v(0, 0, 8'd0, 0, 12'h000, 0, 0, 2, 0, 0, 0, 0, 16'hF002);
      v(0, 1, 8'd8, 0, 12'h000, 0, 0, 2, 0, 0, 0, 0, 16'hF002);
      v(0, 1, 8'd8, 1, 12'h006, 0, 0, 3, 0, 0, 0, 0, 16'hF002);
      v(0, 1, 8'd8, 1, 12'h007, 0, 0, 4, 0, 0, 0, 0, 16'hF002);
      v(0, 1, 8'd8, 1, 12'h008, 0, 0, 5, 0, 0, 0, 0, 16'hF002);
      v(0, 1, 8'd8, 1, 12'h009, 0, 0, 6, 0, 0, 0, 0, 16'hF002);
      v(0, 0, 8'd0, 0, 12'h000, 0, 0, 7, 0, 1, 0, 0, 16'hF002);
      v(0, 0, 8'd0, 0, 12'h000, 0, 0, 7, 0, 0, 0, 0, 16'hF002);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 6, 0, 0, 0, 0, 16'hA007);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 5, 0, 0, 0, 0, 16'h0005);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 4, 0, 0, 0, 0, 16'hA008);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 3, 0, 0, 0, 0, 16'h0006);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 2, 0, 0, 0, 0, 16'h0007);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 1, 0, 0, 0, 0, 16'h0008);
      v(0, 0, 8'd0, 0, 12'h000, 1, 0, 0, 1, 0, 0, 0, 16'h0009);

      foreach (tbl[i]) begin
         bus.FRAME_START    = tbl[i].fs;
         bus.MUX_START      = tbl[i].mux;
         bus.ROWADD         = tbl[i].row;
         bus.ADC_DATA_VALID = tbl[i].vld;
         bus.ADC_DATA       = tbl[i].adc;
         bus.RD_EN          = tbl[i].rd;
         bus.CLR_ERR        = tbl[i].clr;
         step();
         check($sformatf("vec%0d", i), snap(),
               {8'h00, tbl[i].wc, tbl[i].emp, tbl[i].rdone, tbl[i].ov, tbl[i].es, tbl[i].dout});
      end
      idle_inputs();

      // Overflow: nine frame headers (F003..F00B) into an 8-deep FIFO
      for (int i = 0; i < 9; i++) begin
         bus.FRAME_START = 1'b1;
         step();
      end
      bus.FRAME_START = 1'b0;
      check("ovf_before_9th", {27'h0, bus.WORD_COUNT, bus.OVERFLOW}, {27'h0, 4'd8, 1'b0});
      step();
      check("ovf_after_9th", {27'h0, bus.WORD_COUNT, bus.OVERFLOW}, {27'h0, 4'd8, 1'b1});
      for (int i = 0; i < 8; i++) begin
         logic [7:0] fc;
         fc = 8'(i + 3);
         pop_check($sformatf("ovf_pop%0d", i), {8'hF0, fc});
      end
      check("ovf_drained", {27'h0, bus.WORD_COUNT, bus.EMPTY}, {27'h0, 4'd0, 1'b1});

      // Reset mid-row with five words queued
      bus.FRAME_START = 1'b1;
      step();
      bus.FRAME_START = 1'b0;
      bus.MUX_START   = 1'b1;
      bus.ROWADD      = 8'd2;
      step();
      for (int i = 0; i < 3; i++) begin
         bus.ADC_DATA_VALID = 1'b1;
         bus.ADC_DATA       = 12'(i + 16);
         step();
      end
      bus.ADC_DATA_VALID = 1'b0;
      step();
      check("pre_reset_wc", {28'h0, bus.WORD_COUNT}, 32'd5);
      rst_n = 1'b0;
      #1;
      check("mid_row_reset", snap(), {8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      idle_inputs();
      step();
      rst_n = 1'b1;
      step();
      bus.FRAME_START = 1'b1;
      step();
      bus.FRAME_START = 1'b0;
      step();
      pop_check("frame_after_reset", 16'hF000);

      // Frame counter: headers 01..FF, then wrap back to 00
      for (int i = 1; i <= 256; i++) begin
         logic [7:0] fc;
         fc = 8'(i);
         bus.FRAME_START = 1'b1;
         step();
         bus.FRAME_START = 1'b0;
         step();
         pop_check($sformatf("frame_cnt%0d", i), {8'hF0, fc});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter N_COLS, default 128: pixels per row, 2..256.
REQ-002 Parameter FIFO_AW, default 10: FIFO address width, depth 2**FIFO_AW words.
REQ-003 CLK100MHz  in  1  sole clock; every input below is synchronous to it.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 FRAME_START  in  1  one-cycle pulse at frame start.
REQ-006 MUX_START  in  1  row-start level from the readout sequencer; the block acts on its rising edge.
REQ-007 ROWADD  in  8  row address, sampled on the MUX_START rising edge.
REQ-008 ADC_DATA_VALID  in  1  one-cycle strobe per pixel.
REQ-009 ADC_DATA  in  12  pixel value, qualified by ADC_DATA_VALID.
REQ-010 RD_EN  in  1  host read request.
REQ-011 CLR_ERR  in  1  one-cycle pulse that clears the sticky error flags.
REQ-012 DOUT  out  16  FIFO read data.
REQ-013 EMPTY  out  1  FIFO empty.
REQ-014 WORD_COUNT  out  FIFO_AW+1  FIFO occupancy.
REQ-015 ROW_DONE  out  1  one-cycle pulse when the last pixel of a row is written.
REQ-016 OVERFLOW  out  1  sticky: a write was dropped because the FIFO was full.
REQ-017 ERR_STRAY  out  1  sticky: a pixel strobe arrived outside a row.

Function
REQ-018 Word formats: frame header {4'hF,4'h0,frame_cnt[7:0]}; row header {4'hA,4'h0,ROWADD}; pixel {4'h0,ADC_DATA}.
REQ-019 State machine states: IDLE, ROW (collecting pixels).
REQ-020 FRAME_START in any state: push the frame header with the current frame_cnt, then increment frame_cnt (8-bit, wraps 255->0), then go to IDLE; if the block was in ROW, the partial row is abandoned and ROW_DONE is not pulsed.
REQ-021 MUX_START rising edge in IDLE: latch ROWADD, push the row header, clear pix_cnt, go to ROW.
REQ-022 MUX_START rising edge while in ROW: push a new row header and restart pix_cnt at 0 (row truncated).
REQ-023 ADC_DATA_VALID in ROW: push a pixel word and increment pix_cnt.
REQ-024 When pix_cnt reaches N_COLS: pulse ROW_DONE on the same edge the last pixel is written, then go to IDLE.
REQ-025 ADC_DATA_VALID in IDLE: the pixel is dropped and ERR_STRAY is set.
REQ-026 At most one FIFO write per cycle; priority is FRAME_START > row start > pixel.
REQ-027 A pixel that loses arbitration is dropped and sets ERR_STRAY.
REQ-028 Write latency: the event is sampled at edge k; the word is in the FIFO, and EMPTY/WORD_COUNT are updated, at edge k+1.
REQ-029 A write while the FIFO is full is dropped and sets OVERFLOW, even if RD_EN is asserted in the same cycle; the state machine and counters still advance.
REQ-030 Read: RD_EN while not EMPTY pops one word; DOUT is valid from the following edge and holds until the next pop.
REQ-031 RD_EN while EMPTY is ignored.
REQ-032 A simultaneous read and write on a non-full FIFO leaves WORD_COUNT unchanged.
REQ-033 CLR_ERR clears OVERFLOW and ERR_STRAY; if a new error occurs in the same cycle, the flag remains set.

Reset
REQ-034 While RESET_N is low, the following hold immediately: state IDLE, FIFO pointers 0, EMPTY=1, WORD_COUNT=0, DOUT=0, ROW_DONE=0, OVERFLOW=0, ERR_STRAY=0, frame_cnt=0, pix_cnt=0, MUX_START edge detector=0.
REQ-035 Reset mid-row discards all FIFO contents; no partial state survives reset.

Structure
REQ-036 A shared package holds the tag constants (TAG_FRAME=4'hF, TAG_ROW=4'hA, TAG_PIX=4'h0) and the state encoding.
REQ-037 The FIFO is a separate sub-module, pix_fifo: synchronous, one clock, registered read, full/empty/count outputs.

Verification
REQ-038 N_COLS=4: FRAME_START, MUX_START with ROWADD=5, 4 strobes with data 1,2,3,4 -> FIFO holds F000, A005, 0001, 0002, 0003, 0004; ROW_DONE pulses once, on the 4th write.
REQ-039 256 FRAME_START pulses -> frame header low bytes run 00..FF; the 257th header reads F000.
REQ-040 Strobe with no row open, then CLR_ERR -> no word written, ERR_STRAY=1, then 0 after CLR_ERR.
REQ-041 FIFO_AW=3: push 9 words with no reads -> WORD_COUNT=8, OVERFLOW=1; 9th word absent; RD_EN x8 returns the first 8 words in order, then EMPTY=1.
REQ-042 FRAME_START in the same cycle as a strobe, 2 pixels into a row -> frame header written, pixel dropped, ERR_STRAY=1, no ROW_DONE, state IDLE.
REQ-043 RESET_N low mid-row with WORD_COUNT=5 -> EMPTY=1, WORD_COUNT=0, all flags 0; the next frame header reads F000.
